// File: rtl/pipe_hazard_unit.sv
// Scoreboard-style hazard tracker for a short in-order pipeline.
// It tracks the destinations of the instructions that have left decode.
// It produces operand bypass selects for the decoding instruction.
// It stalls decode on load-use hazards and drives the write-back (commit) port.
//
// Issue handshake: decode presents an instruction with issue_valid_i and keeps
// it stable. The instruction is taken on the rising edge where issue_valid_i is
// high and stall_o, flush_i and hold_i are all low. stall_o acts as an inverted
// ready and never depends on flush_i.
module pipe_hazard_unit #(
    parameter int RF_ADDR_W  = 6,
    parameter int STAGES     = 3,
    parameter int LOAD_STAGE = 2,
    parameter int SEL_W      = $clog2(STAGES + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 issue_valid_i,
    input  logic [RF_ADDR_W-1:0] issue_rd_i,
    input  logic                 issue_writes_rf_i,
    input  logic                 issue_is_load_i,
    input  logic [RF_ADDR_W-1:0] rs_addr_i,
    input  logic [RF_ADDR_W-1:0] rd_addr_i,
    input  logic                 hold_i,
    input  logic                 flush_i,
    output logic                 stall_o,
    output logic [SEL_W-1:0]     byp_rs_sel_o,
    output logic [SEL_W-1:0]     byp_rd_sel_o,
    output logic                 commit_valid_o,
    output logic [RF_ADDR_W-1:0] commit_rd_o,
    output logic [2:0]           inflight_o
);

    // Per-stage tracking fields; index 1 is the youngest entry.
    logic [STAGES:1]      st_valid;
    logic [STAGES:1]      st_wr;
    logic [STAGES:1]      st_ld;
    logic [RF_ADDR_W-1:0] st_rd [1:STAGES];

    logic [STAGES:1] rs_match;
    logic [STAGES:1] rd_match;
    logic            rs_lu;
    logic            rd_lu;
    logic            load_use;
    logic            accept;
    logic [STAGES:1] nxt_valid;
    logic [3:0]      nxt_count;
    logic [2:0]      nxt_inflight;

    // Compare both sources against every tracked writer; r0 never matches.
    always_comb begin
        rs_match = '0;
        rd_match = '0;
        for (int k = 1; k <= STAGES; k++) begin
            rs_match[k] = issue_valid_i & st_valid[k] & st_wr[k] &
                          (st_rd[k] == rs_addr_i) & (rs_addr_i != '0);
            rd_match[k] = issue_valid_i & st_valid[k] & st_wr[k] &
                          (st_rd[k] == rd_addr_i) & (rd_addr_i != '0);
        end
    end

    // Youngest matching producer wins; remember if it is a load not yet bypassable.
    always_comb begin
        byp_rs_sel_o = '0;
        byp_rd_sel_o = '0;
        rs_lu        = 1'b0;
        rd_lu        = 1'b0;
        for (int k = STAGES; k >= 1; k--) begin
            if (rs_match[k]) begin
                byp_rs_sel_o = SEL_W'(k);
                rs_lu        = st_ld[k] & (k < LOAD_STAGE);
            end
            if (rd_match[k]) begin
                byp_rd_sel_o = SEL_W'(k);
                rd_lu        = st_ld[k] & (k < LOAD_STAGE);
            end
        end
    end

    // Stall, acceptance and commit port; stall is forced low while reset is held.
    always_comb begin
        load_use       = rs_lu | rd_lu;
        stall_o        = reset & (hold_i | load_use);
        accept         = issue_valid_i & ~stall_o & ~flush_i & ~hold_i;
        commit_valid_o = st_valid[STAGES] & st_wr[STAGES] & ~hold_i;
        commit_rd_o    = commit_valid_o ? st_rd[STAGES] : '0;
    end

    // Next valid vector: a flush kills the entry leaving stage 1.
    always_comb begin
        nxt_valid    = '0;
        nxt_valid[1] = accept;
        for (int k = 2; k <= STAGES; k++) begin
            nxt_valid[k] = st_valid[k-1];
        end
        nxt_valid[2] = st_valid[1] & ~flush_i;
    end

    // Population count of the next valid vector, saturated to the 3-bit output.
    always_comb begin
        nxt_count = '0;
        for (int k = 1; k <= STAGES; k++) begin
            nxt_count = nxt_count + 4'(nxt_valid[k]);
        end
        nxt_inflight = (nxt_count > 4'd7) ? 3'd7 : nxt_count[2:0];
    end

    // Shift the tracker each non-held cycle; reset empties it asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st_valid   <= '0;
            st_wr      <= '0;
            st_ld      <= '0;
            inflight_o <= '0;
            for (int k = 1; k <= STAGES; k++) begin
                st_rd[k] <= '0;
            end
        end else if (!hold_i) begin
            st_valid   <= nxt_valid;
            inflight_o <= nxt_inflight;
            st_wr[1]   <= issue_writes_rf_i;
            st_ld[1]   <= issue_is_load_i;
            st_rd[1]   <= issue_rd_i;
            for (int k = 2; k <= STAGES; k++) begin
                st_wr[k] <= st_wr[k-1];
                st_ld[k] <= st_ld[k-1];
                st_rd[k] <= st_rd[k-1];
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Self-checking bench for pipe_hazard_unit: a STAGES=3 and a STAGES=5 instance
// share one stimulus stream and are compared every cycle against a
// behavioural tracker model, with directed scenarios pinned by literals.
module tb_pipe_hazard_unit;

    localparam int LS = 2;

    typedef struct packed {
        logic       v;
        logic [5:0] rd;
        logic       w;
        logic       l;
    } ent_t;

    // clock / reset
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic       issue_valid = 1'b0;
    logic [5:0] issue_rd = '0;
    logic       issue_w = 1'b0;
    logic       issue_l = 1'b0;
    logic [5:0] rs_addr = '0;
    logic [5:0] rd_addr = '0;
    logic       hold = 1'b0;
    logic       flush = 1'b0;

    logic       stall_0, cv_0;
    logic [1:0] rs_sel_0, rd_sel_0;
    logic [5:0] crd_0;
    logic [2:0] infl_0;
    logic       stall_1, cv_1;
    logic [2:0] rs_sel_1, rd_sel_1;
    logic [5:0] crd_1;
    logic [2:0] infl_1;

    pipe_hazard_unit #(.RF_ADDR_W(6), .STAGES(3), .LOAD_STAGE(LS)) dut3 (
        .clk(clk), .reset(reset),
        .issue_valid_i(issue_valid), .issue_rd_i(issue_rd),
        .issue_writes_rf_i(issue_w), .issue_is_load_i(issue_l),
        .rs_addr_i(rs_addr), .rd_addr_i(rd_addr),
        .hold_i(hold), .flush_i(flush),
        .stall_o(stall_0), .byp_rs_sel_o(rs_sel_0), .byp_rd_sel_o(rd_sel_0),
        .commit_valid_o(cv_0), .commit_rd_o(crd_0), .inflight_o(infl_0)
    );

    pipe_hazard_unit #(.RF_ADDR_W(6), .STAGES(5), .LOAD_STAGE(LS)) dut5 (
        .clk(clk), .reset(reset),
        .issue_valid_i(issue_valid), .issue_rd_i(issue_rd),
        .issue_writes_rf_i(issue_w), .issue_is_load_i(issue_l),
        .rs_addr_i(rs_addr), .rd_addr_i(rd_addr),
        .hold_i(hold), .flush_i(flush),
        .stall_o(stall_1), .byp_rs_sel_o(rs_sel_1), .byp_rd_sel_o(rd_sel_1),
        .commit_valid_o(cv_1), .commit_rd_o(crd_1), .inflight_o(infl_1)
    );

    // model state and scoreboard counters
    ent_t m [0:1][1:6];
    int   m_infl [0:1];
    int   n_checks = 0;
    int   n_errors = 0;
    int   o_stall [0:1];
    int   o_rs [0:1];
    int   o_rd [0:1];
    int   o_cv [0:1];
    int   o_crd [0:1];
    int   o_infl [0:1];

    function automatic int ns_of(input int d);
        return (d == 0) ? 3 : 5;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // youngest valid writer of src, 0 if none or not checked
    function automatic int model_find(input int d, input logic [5:0] src);
        if (!issue_valid || src == 6'd0) return 0;
        for (int k = 1; k <= ns_of(d); k++) begin
            if (m[d][k].v && m[d][k].w && m[d][k].rd == src) return k;
        end
        return 0;
    endfunction

    function automatic bit model_stall(input int d);
        int  krs;
        int  krd;
        bit  lu;
        if (!reset) return 1'b0;
        krs = model_find(d, rs_addr);
        krd = model_find(d, rd_addr);
        lu  = (krs != 0 && m[d][krs].l && krs < LS) ||
              (krd != 0 && m[d][krd].l && krd < LS);
        return hold || lu;
    endfunction

    task automatic model_clear();
        for (int d = 0; d < 2; d++) begin
            for (int k = 1; k <= 6; k++) m[d][k] = '0;
            m_infl[d] = 0;
        end
    endtask

    task automatic model_update();
        if (!reset) return;
        for (int d = 0; d < 2; d++) begin
            bit   acc;
            int   cnt;
            ent_t fresh;
            if (hold) continue;
            acc = issue_valid && !model_stall(d) && !flush;
            for (int k = ns_of(d); k >= 2; k--) m[d][k] = m[d][k-1];
            if (flush) m[d][2].v = 1'b0;
            fresh.v  = acc;
            fresh.rd = issue_rd;
            fresh.w  = issue_w;
            fresh.l  = issue_l;
            m[d][1]  = fresh;
            cnt = 0;
            for (int k = 1; k <= ns_of(d); k++) cnt += int'(m[d][k].v);
            m_infl[d] = (cnt > 7) ? 7 : cnt;
        end
    endtask

    // compare process: every output of both instances against the model
    task automatic check_all();
        o_stall[0] = int'(stall_0); o_rs[0] = int'(rs_sel_0); o_rd[0] = int'(rd_sel_0);
        o_cv[0] = int'(cv_0); o_crd[0] = int'(crd_0); o_infl[0] = int'(infl_0);
        o_stall[1] = int'(stall_1); o_rs[1] = int'(rs_sel_1); o_rd[1] = int'(rd_sel_1);
        o_cv[1] = int'(cv_1); o_crd[1] = int'(crd_1); o_infl[1] = int'(infl_1);
        for (int d = 0; d < 2; d++) begin
            int ns;
            bit ecv;
            ns  = ns_of(d);
            ecv = reset && m[d][ns].v && m[d][ns].w && !hold;
            chk($sformatf("s%0d_stall", ns), o_stall[d], int'(model_stall(d)));
            chk($sformatf("s%0d_rs_sel", ns), o_rs[d], model_find(d, rs_addr));
            chk($sformatf("s%0d_rd_sel", ns), o_rd[d], model_find(d, rd_addr));
            chk($sformatf("s%0d_commit_valid", ns), o_cv[d], int'(ecv));
            chk($sformatf("s%0d_commit_rd", ns), o_crd[d], ecv ? int'(m[d][ns].rd) : 0);
            chk($sformatf("s%0d_inflight", ns), o_infl[d], m_infl[d]);
        end
    endtask

    // driver: one decode cycle
    task automatic drive(input logic iv, input int rd_, input logic w, input logic l,
                         input int rs, input int rds, input logic h, input logic f);
        @(negedge clk);
        reset       = 1'b1;
        issue_valid = iv;
        issue_rd    = 6'(rd_);
        issue_w     = w;
        issue_l     = l;
        rs_addr     = 6'(rs);
        rd_addr     = 6'(rds);
        hold        = h;
        flush       = f;
        #1;
        check_all();
        @(posedge clk);
        model_update();
    endtask

    task automatic nop();
        drive(1'b0, 0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    endtask

    // hold reset low (with hold and a valid issue present) for a few cycles
    task automatic do_reset(input int cycles);
        @(negedge clk);
        reset       = 1'b0;
        hold        = 1'b1;
        issue_valid = 1'b1;
        flush       = 1'b0;
        #1;
        model_clear();
        check_all();
        repeat (cycles) begin
            @(negedge clk);
            #1;
            check_all();
        end
    endtask

    logic [5:0] got [0:1][$];

    task automatic collect_commits(input int n);
        got[0].delete();
        got[1].delete();
        repeat (n) begin
            nop();
            if (o_cv[0] != 0) got[0].push_back(6'(o_crd[0]));
            if (o_cv[1] != 0) got[1].push_back(6'(o_crd[1]));
        end
    endtask

    initial begin
        model_clear();
        do_reset(2);
        chk("reset_stall", o_stall[0], 0);
        chk("reset_inflight", o_infl[0], 0);

        // back-to-back ALU forwarding
        drive(1, 5, 1, 0, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 5, 0, 0, 0);
        chk("alu_sel1_s3", o_rs[0], 1);
        chk("alu_sel1_s5", o_rs[1], 1);
        chk("alu_nostall", o_stall[0], 0);
        chk("first_accept_inflight", o_infl[0], 1);
        drive(1, 1, 0, 0, 5, 0, 0, 0);
        chk("alu_sel2_s3", o_rs[0], 2);
        chk("alu_sel2_s5", o_rs[1], 2);
        repeat (6) nop();

        // load-use: one stall cycle, then forward from stage 2
        drive(1, 7, 1, 1, 0, 0, 0, 0);
        drive(1, 2, 1, 0, 7, 0, 0, 0);
        chk("lu_stall_s3", o_stall[0], 1);
        chk("lu_stall_s5", o_stall[1], 1);
        chk("lu_sel_during_stall", o_rs[0], 1);
        drive(1, 2, 1, 0, 7, 0, 0, 0);
        chk("lu_release_stall", o_stall[0], 0);
        chk("lu_sel2_s3", o_rs[0], 2);
        chk("lu_sel2_s5", o_rs[1], 2);
        chk("lu_bubble_inflight", o_infl[0], 1);
        nop();
        chk("lu_after_inflight_s3", o_infl[0], 2);
        chk("lu_after_inflight_s5", o_infl[1], 2);
        repeat (6) nop();

        // youngest producer wins
        drive(1, 9, 1, 0, 0, 0, 0, 0);
        drive(1, 10, 1, 0, 0, 0, 0, 0);
        drive(1, 9, 1, 0, 0, 0, 0, 0);
        drive(1, 3, 0, 0, 10, 9, 0, 0);
        chk("young_rd_sel_s3", o_rd[0], 1);
        chk("young_rd_sel_s5", o_rd[1], 1);
        chk("young_rs_sel", o_rs[0], 2);
        repeat (6) nop();

        // flush kills the entry leaving stage 1
        drive(1, 4, 1, 0, 0, 0, 0, 0);
        drive(1, 8, 1, 0, 0, 0, 0, 1);
        collect_commits(7);
        chk("flush_no_commit_s3", got[0].size(), 0);
        chk("flush_no_commit_s5", got[1].size(), 0);
        drive(1, 3, 0, 0, 4, 0, 0, 0);
        chk("flush_sel0", o_rs[0], 0);
        repeat (6) nop();

        // hold freezes three in-flight entries, then they commit in order
        drive(1, 11, 1, 0, 0, 0, 0, 0);
        drive(1, 12, 1, 0, 0, 0, 0, 0);
        drive(1, 13, 1, 0, 0, 0, 0, 0);
        repeat (4) begin
            drive(0, 0, 0, 0, 0, 0, 1, 0);
            chk("hold_commit_valid", o_cv[0], 0);
            chk("hold_stall", o_stall[0], 1);
            chk("hold_inflight", o_infl[0], 3);
        end
        collect_commits(6);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("hold_commits_%0d", d), got[d].size(), 3);
            for (int i = 0; i < 3 && i < got[d].size(); i++) begin
                chk($sformatf("hold_order_%0d_%0d", d, i), int'(got[d][i]), 11 + i);
            end
        end

        // register 0 is never matched
        drive(1, 0, 1, 1, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 0, 0, 0, 0);
        chk("r0_sel", o_rs[0], 0);
        chk("r0_stall", o_stall[0], 0);
        repeat (6) nop();

        // reset mid-stream discards in-flight work
        drive(1, 20, 1, 0, 0, 0, 0, 0);
        drive(1, 21, 1, 0, 0, 0, 0, 0);
        do_reset(1);
        chk("midreset_stall", o_stall[0], 0);
        chk("midreset_inflight", o_infl[1], 0);
        collect_commits(6);
        chk("midreset_no_commit_s3", got[0].size(), 0);
        chk("midreset_no_commit_s5", got[1].size(), 0);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset($urandom_range(0, 2));
            end else begin
                drive($urandom_range(0, 3) != 0, $urandom_range(0, 7),
                      $urandom_range(0, 4) != 0, $urandom_range(0, 2) == 0,
                      $urandom_range(0, 7), $urandom_range(0, 7),
                      $urandom_range(0, 9) == 0, $urandom_range(0, 11) == 0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
